// File: rtl/agc_pinc_pkg.sv
// Shared definitions for the PIPA increment scheduler: source indices,
// axis codes, arbiter state type and widths.
// Optional build macro used by the consumers of this package: PINC_RR_EN.
package agc_pinc_pkg;

  localparam int unsigned SRC_N  = 6;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned AXIS_W = 2;

  // Source bit positions (same order as PIPIN / PEND)
  localparam int unsigned SRC_XP = 0;
  localparam int unsigned SRC_XM = 1;
  localparam int unsigned SRC_YP = 2;
  localparam int unsigned SRC_YM = 3;
  localparam int unsigned SRC_ZP = 4;
  localparam int unsigned SRC_ZM = 5;

  // Counter address codes
  localparam logic [AXIS_W-1:0] AXIS_X = 2'd0;
  localparam logic [AXIS_W-1:0] AXIS_Y = 2'd1;
  localparam logic [AXIS_W-1:0] AXIS_Z = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } pinc_state_e;

endpackage

// File: rtl/pinc_pri_enc.sv
// Combinational arbiter: cancels axes with both P and M pending, then picks
// one remaining source.
//   pend_i   : pending latches
//   start_i  : round-robin search start (only with PINC_RR_EN)
//   valid_c  : a source remains after cancellation
//   idx_c    : selected source index
//   cancel_c : bits cleared by P/M cancellation
// Build macro: PINC_RR_EN selects round-robin instead of fixed priority.
module pinc_pri_enc
  import agc_pinc_pkg::*;
(
`ifdef PINC_RR_EN
  input  logic [IDX_W-1:0] start_i,
`endif
  input  logic [SRC_N-1:0] pend_i,
  output logic             valid_c,
  output logic [IDX_W-1:0] idx_c,
  output logic [SRC_N-1:0] cancel_c
);

  logic [SRC_N-1:0] rem_c;

  // Opposing pulses on one axis cancel each other out
  always_comb begin
    cancel_c = '0;
    for (int a = 0; a < 3; a++) begin
      if (pend_i[2*a] && pend_i[2*a+1]) cancel_c[2*a +: 2] = 2'b11;
    end
  end

  assign rem_c   = pend_i & ~cancel_c;
  assign valid_c = |rem_c;

`ifdef PINC_RR_EN
  int j_c;

  // Scan downward so the candidate nearest to start_i is written last
  always_comb begin
    idx_c = '0;
    j_c   = 0;
    for (int k = int'(SRC_N) - 1; k >= 0; k--) begin
      j_c = (int'(start_i) + k) % int'(SRC_N);
      if (rem_c[j_c]) idx_c = IDX_W'(j_c);
    end
  end
`else
  // Lowest index wins: XP > XM > YP > YM > ZP > ZM
  always_comb begin
    idx_c = '0;
    for (int i = int'(SRC_N) - 1; i >= 0; i--) begin
      if (rem_c[i]) idx_c = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/pinc_sched.sv
// PIPA increment scheduler: latches accelerometer pulses, arbitrates them
// one per counter slot and hands each to the shared counter unit.
//   CLOCK, rst (async, active-low)
//   PIPIN    : pulse inputs XP,XM,YP,YM,ZP,ZM
//   T_SLOT   : counter slot strobe       CTR_ACK  : counter took increment
//   GOJAM    : synchronous restart       CLR_FAIL : clear overrun flag
//   CTR_REQ/CTR_ADDR/CTR_SIGN : registered increment request
//   PIPAFL   : sticky overrun flag       PEND     : pending latches
// Build macro: PINC_RR_EN enables round-robin arbitration.
module pinc_sched
  import agc_pinc_pkg::*;
(
  input  logic              CLOCK,
  input  logic              rst,
  input  logic [SRC_N-1:0]  PIPIN,
  input  logic              T_SLOT,
  input  logic              CTR_ACK,
  input  logic              GOJAM,
  input  logic              CLR_FAIL,
  output logic              CTR_REQ,
  output logic [AXIS_W-1:0] CTR_ADDR,
  output logic              CTR_SIGN,
  output logic              PIPAFL,
  output logic [SRC_N-1:0]  PEND
);

  pinc_state_e       state_q, state_d;
  logic [SRC_N-1:0]  pend_q, pend_d;
  logic              fail_q, fail_d;
  logic              req_q, req_d;
  logic [AXIS_W-1:0] addr_q, addr_d;
  logic              sign_q, sign_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;

  logic              valid_c;
  logic [IDX_W-1:0]  idx_c;
  logic [SRC_N-1:0]  cancel_c;
  logic [SRC_N-1:0]  clr_c;
  logic [SRC_N-1:0]  ovr_c;

`ifdef PINC_RR_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

  pinc_pri_enc u_pri_enc (
`ifdef PINC_RR_EN
    .start_i  (ptr_q),
`endif
    .pend_i   (pend_q),
    .valid_c  (valid_c),
    .idx_c    (idx_c),
    .cancel_c (cancel_c)
  );

  // Next-state: arbitration, grant completion, pulse capture, overrun flag
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fail_d  = fail_q;
    req_d   = req_q;
    addr_d  = addr_q;
    sign_d  = sign_q;
    gidx_d  = gidx_q;
    clr_c   = '0;
    ovr_c   = '0;
`ifdef PINC_RR_EN
    ptr_d   = ptr_q;
`endif
    if (GOJAM) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      req_d   = 1'b0;
      addr_d  = '0;
      sign_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (T_SLOT) begin
            clr_c = cancel_c;
            if (valid_c) begin
              state_d = ST_REQ;
              req_d   = 1'b1;
              addr_d  = AXIS_W'(idx_c >> 1);
              sign_d  = idx_c[0];
              gidx_d  = idx_c;
            end
          end
        end
        ST_REQ: begin
          if (CTR_ACK) begin
            clr_c[gidx_q] = 1'b1;
            state_d       = ST_IDLE;
            req_d         = 1'b0;
`ifdef PINC_RR_EN
            ptr_d = (gidx_q == IDX_W'(SRC_N - 1)) ? '0 : gidx_q + IDX_W'(1);
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A pulse landing on a bit being cleared this edge is not an overrun
      ovr_c  = PIPIN & pend_q & ~clr_c;
      pend_d = (pend_q & ~clr_c) | PIPIN;
      if (|ovr_c)        fail_d = 1'b1;
      else if (CLR_FAIL) fail_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      fail_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      sign_q  <= 1'b0;
      gidx_q  <= '0;
`ifdef PINC_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fail_q  <= fail_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      sign_q  <= sign_d;
      gidx_q  <= gidx_d;
`ifdef PINC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign CTR_REQ  = req_q;
  assign CTR_ADDR = addr_q;
  assign CTR_SIGN = sign_q;
  assign PIPAFL   = fail_q;
  assign PEND     = pend_q;

endmodule

// File: tb/tb_pinc_sched.sv
// Self-checking bench for pinc_sched: reference model plus directed vectors.
module tb_pinc_sched;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] PIPIN = '0;
  logic       T_SLOT = 1'b0, CTR_ACK = 1'b0, GOJAM = 1'b0, CLR_FAIL = 1'b0;
  logic       CTR_REQ, CTR_SIGN, PIPAFL;
  logic [1:0] CTR_ADDR;
  logic [5:0] PEND;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 1'b0;

  pinc_sched dut (
    .CLOCK(CLOCK), .rst(rst), .PIPIN(PIPIN), .T_SLOT(T_SLOT),
    .CTR_ACK(CTR_ACK), .GOJAM(GOJAM), .CLR_FAIL(CLR_FAIL),
    .CTR_REQ(CTR_REQ), .CTR_ADDR(CTR_ADDR), .CTR_SIGN(CTR_SIGN),
    .PIPAFL(PIPAFL), .PEND(PEND)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending set, grant in flight, overrun flag
  bit [5:0] m_pend;
  bit       m_req, m_sign, m_fail;
  int       m_addr, m_g, m_ptr;
  bit [5:0] m_clr;
  int       m_sel;

  always @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      m_pend = '0; m_req = 0; m_sign = 0; m_fail = 0;
      m_addr = 0; m_g = 0; m_ptr = 0;
    end else if (GOJAM) begin
      m_pend = '0; m_req = 0; m_addr = 0; m_sign = 0;
    end else begin
      m_clr = '0;
      if (!m_req && T_SLOT) begin
        for (int a = 0; a < 3; a++)
          if (m_pend[2*a] && m_pend[2*a+1]) begin
            m_clr[2*a] = 1; m_clr[2*a+1] = 1;
          end
        m_sel = -1;
`ifdef PINC_RR_EN
        for (int k = 0; k < 6; k++)
          if (m_sel < 0 && m_pend[(m_ptr + k) % 6] && !m_clr[(m_ptr + k) % 6])
            m_sel = (m_ptr + k) % 6;
`else
        for (int s = 0; s < 6; s++)
          if (m_sel < 0 && m_pend[s] && !m_clr[s]) m_sel = s;
`endif
        if (m_sel >= 0) begin
          m_req = 1; m_g = m_sel; m_addr = m_sel / 2; m_sign = (m_sel % 2) == 1;
        end
      end else if (m_req && CTR_ACK) begin
        m_clr[m_g] = 1;
        m_req = 0;
        m_ptr = (m_g + 1) % 6;
      end
      if ((PIPIN & m_pend & ~m_clr) != 0) m_fail = 1;
      else if (CLR_FAIL) m_fail = 0;
      m_pend = (m_pend & ~m_clr) | PIPIN;
    end
  end

  // Every out-of-reset cycle: DUT against model
  always @(negedge CLOCK) begin
    if (rst && started) begin
      chk("m_pend", int'(PEND), int'(m_pend));
      chk("m_req",  int'(CTR_REQ), int'(m_req));
      chk("m_addr", int'(CTR_ADDR), m_addr);
      chk("m_sign", int'(CTR_SIGN), int'(m_sign));
      chk("m_fail", int'(PIPAFL), int'(m_fail));
    end
  end

  // One clock with the given inputs, then inputs return to idle
  task automatic cyc(input logic [5:0] pip, input logic ts, input logic ack,
                     input logic gj, input logic cf);
    PIPIN = pip; T_SLOT = ts; CTR_ACK = ack; GOJAM = gj; CLR_FAIL = cf;
    @(posedge CLOCK);
    #1;
    PIPIN = '0; T_SLOT = 0; CTR_ACK = 0; GOJAM = 0; CLR_FAIL = 0;
  endtask

  task automatic look(input string n, input int req, input int addr,
                      input int sign, input int pend);
    chk({n, "_req"}, int'(CTR_REQ), req);
    if (req != 0) begin
      chk({n, "_addr"}, int'(CTR_ADDR), addr);
      chk({n, "_sign"}, int'(CTR_SIGN), sign);
    end
    chk({n, "_pend"}, int'(PEND), pend);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_pend", int'(PEND), 0);
    chk("rst_req", int'(CTR_REQ), 0);
    chk("rst_fail", int'(PIPAFL), 0);
    chk("rst_addr", int'(CTR_ADDR), 0);
    rst = 1'b1;
    started = 1'b1;
    cyc(6'b0, 0, 0, 0, 0);

    // single XP: grant, hold, complete
    cyc(6'b000001, 0, 0, 0, 0); look("xp_lat", 0, 0, 0, 6'b000001);
    cyc(6'b0, 1, 0, 0, 0);      look("xp_gnt", 1, 0, 0, 6'b000001);
    cyc(6'b0, 0, 0, 0, 0);      look("xp_hold", 1, 0, 0, 6'b000001);
    cyc(6'b0, 0, 1, 0, 0);      look("xp_ack", 0, 0, 0, 6'b0);

    // YP+YM cancel, no request
    cyc(6'b001100, 0, 0, 0, 0); look("y_lat", 0, 0, 0, 6'b001100);
    cyc(6'b0, 1, 0, 0, 0);      look("y_cnc", 0, 0, 0, 6'b0);

    // XP then ZM
    cyc(6'b100001, 0, 0, 0, 0); look("xz_lat", 0, 0, 0, 6'b100001);
    cyc(6'b0, 1, 0, 0, 0);      look("xz_g1", 1, 0, 0, 6'b100001);
    cyc(6'b0, 0, 1, 0, 0);      look("xz_a1", 0, 0, 0, 6'b100000);
    cyc(6'b0, 1, 0, 0, 0);      look("xz_g2", 1, 2, 1, 6'b100000);
    cyc(6'b0, 0, 1, 0, 0);      look("xz_a2", 0, 0, 0, 6'b0);

    // ACK in IDLE ignored
    cyc(6'b0, 0, 1, 0, 0);      look("ack_idle", 0, 0, 0, 6'b0);

    // overrun, GOJAM keeps flag, CLR_FAIL clears it
    cyc(6'b000100, 0, 0, 0, 0);
    cyc(6'b000100, 0, 0, 0, 0); chk("ovr_fail", int'(PIPAFL), 1);
    chk("ovr_pend", int'(PEND), 6'b000100);
    cyc(6'b0, 0, 0, 1, 0);      chk("gj_pend", int'(PEND), 0);
    chk("gj_fail", int'(PIPAFL), 1);
    cyc(6'b0, 0, 0, 0, 1);      chk("cf_fail", int'(PIPAFL), 0);

    // pulse on the completing bit: stays pending, no overrun
    cyc(6'b000010, 0, 0, 0, 0);
    cyc(6'b0, 1, 0, 0, 0);      look("xm_gnt", 1, 0, 1, 6'b000010);
    cyc(6'b000010, 0, 1, 0, 0); look("xm_re", 0, 0, 0, 6'b000010);
    chk("xm_re_fail", int'(PIPAFL), 0);

    // opposite bit during REQ does not cancel the grant; T_SLOT in REQ ignored
    cyc(6'b0, 1, 0, 0, 0);      look("opp_gnt", 1, 0, 1, 6'b000010);
    cyc(6'b000001, 1, 0, 0, 0); look("opp_arr", 1, 0, 1, 6'b000011);
    cyc(6'b0, 0, 1, 0, 0);      look("opp_ack", 0, 0, 0, 6'b000001);
    cyc(6'b0, 1, 0, 0, 0);      look("opp_g2", 1, 0, 0, 6'b000001);
    cyc(6'b0, 0, 1, 0, 0);

    // mixed cancel + priority: Z cancels, XM then YP
    cyc(6'b110110, 0, 0, 0, 0);
    cyc(6'b0, 1, 0, 0, 0);      look("mix_g1", 1, 0, 1, 6'b000110);
    cyc(6'b0, 0, 1, 0, 0);      look("mix_a1", 0, 0, 0, 6'b000100);
    cyc(6'b0, 1, 0, 0, 0);      look("mix_g2", 1, 1, 0, 6'b000100);
    cyc(6'b0, 0, 1, 0, 0);      look("mix_a2", 0, 0, 0, 6'b0);

    // GOJAM beats ACK and PIPIN
    cyc(6'b010000, 0, 0, 0, 0);
    cyc(6'b0, 1, 0, 0, 0);      look("gj_g", 1, 2, 0, 6'b010000);
    cyc(6'b000100, 0, 1, 1, 0); look("gj_win", 0, 0, 0, 6'b0);

    // CLR_FAIL with simultaneous overrun keeps flag set
    cyc(6'b001000, 0, 0, 0, 0);
    cyc(6'b001000, 0, 0, 0, 1); chk("cfo_fail", int'(PIPAFL), 1);
    cyc(6'b0, 0, 0, 0, 1);      chk("cfo_clr", int'(PIPAFL), 0);
    cyc(6'b0, 0, 0, 1, 0);

    // pseudo-random traffic, model-checked
    for (int n = 0; n < 400; n++) begin
      logic [5:0] p;
      p = 6'($urandom) & 6'($urandom) & 6'($urandom);
      cyc(p, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 15) == 0));
    end
    cyc(6'b0, 0, 0, 1, 0);

    // async reset mid-REQ
    cyc(6'b100000, 0, 0, 0, 0);
    cyc(6'b0, 1, 0, 0, 0);      look("ar_g", 1, 2, 1, 6'b100000);
    #1 rst = 1'b0;
    #1;
    chk("ar_req", int'(CTR_REQ), 0);
    chk("ar_pend", int'(PEND), 0);
    chk("ar_addr", int'(CTR_ADDR), 0);
    repeat (2) @(posedge CLOCK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
